pc_redirect_ctrl: RTL and testbench

Sequencer that drives the PC datapath's `halt`, `jreq` and `jval` inputs. It arbitrates every source of control-flow change: the execute-stage branch, the synchronous trap, the external interrupt, trap return and debug halt/resume. Redirects that arrive while memory stalls the pipe are held in a pending slot. After each redirect it produces the flush window that squashes wrong-path instructions. It sits between the PC register block and the decode/execute/memory stages of the core.

---
 rtl/pc_redirect_ctrl_if.sv | 38 +++
 rtl/pc_redirect_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_ctrl_if.sv
// Control-flow redirect bundle between the pipeline stages, the PC block and
// the redirect sequencer. The controller takes the slave side; whatever feeds
// requests and consumes halt/jreq/jval takes the master side.
interface pc_redirect_ctrl_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] next_pc;
  logic            mem_busy;
  logic            br_req;
  logic [XLEN-1:0] br_target;
  logic            trap_req;
  logic [XLEN-1:0] trap_pc;
  logic            mret_req;
  logic            irq;
  logic            irq_en;
  logic [XLEN-1:0] mtvec;
  logic            dbg_halt_req;
  logic            dbg_resume_req;
  logic            halt;
  logic            jreq;
  logic [XLEN-1:0] jval;
  logic            flush;
  logic [XLEN-1:0] mepc;
  logic            in_trap;
  logic            halted;

  modport slave (
    input  next_pc, mem_busy, br_req, br_target, trap_req, trap_pc, mret_req,
           irq, irq_en, mtvec, dbg_halt_req, dbg_resume_req,
    output halt, jreq, jval, flush, mepc, in_trap, halted
  );

  modport master (
    output next_pc, mem_busy, br_req, br_target, trap_req, trap_pc, mret_req,
           irq, irq_en, mtvec, dbg_halt_req, dbg_resume_req,
    input  halt, jreq, jval, flush, mepc, in_trap, halted
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Redirect sequencer for the PC block: arbitrates trap / interrupt / mret /
// branch, parks redirects that arrive during a memory stall, generates the
// post-redirect flush window and handles debug halt/resume.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_RUN    | normal execution, redirects issued when memory is not busy
// S_FLUSH  | squashing wrong-path fetch/decode for FLUSH_CYCLES cycles
// S_HALTED | debug-halted, waiting for dbg_resume_req
module pc_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              xreset_n,
  pc_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_RUN = 2'd0, S_FLUSH = 2'd1, S_HALTED = 2'd2} state_t;
  // Numeric value doubles as priority rank among live requests
  typedef enum logic [2:0] {
    K_NONE = 3'd0, K_BR = 3'd1, K_MRET = 3'd2, K_IRQ = 3'd3, K_TRAP = 3'd4
  } kind_t;

  state_t          state_q, state_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic            pend_valid_q, pend_valid_d;
  kind_t           pend_kind_q, pend_kind_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic [XLEN-1:0] pend_epc_q, pend_epc_d;
  logic            dbg_pend_q, dbg_pend_d;
  logic            in_trap_q, in_trap_d;
  logic [XLEN-1:0] mepc_q, mepc_d;

  kind_t           new_kind, sel_kind;
  logic [XLEN-1:0] new_target, new_epc, sel_target, sel_epc;
  logic            irq_live;
  logic            halt_c, jreq_c;
  logic [XLEN-1:0] jval_c;

  // Highest-priority request presented this cycle, ignoring the pending slot
  always_comb begin
    irq_live   = bus.irq & bus.irq_en & ~in_trap_q;
    new_kind   = K_NONE;
    new_target = '0;
    new_epc    = '0;
    if (bus.trap_req) begin
      new_kind   = K_TRAP;
      new_target = bus.mtvec;
      new_epc    = bus.trap_pc;
    end else if (irq_live) begin
      new_kind   = K_IRQ;
      new_target = bus.mtvec;
      new_epc    = bus.next_pc;
    end else if (bus.mret_req) begin
      new_kind   = K_MRET;
      new_target = mepc_q;
    end else if (bus.br_req) begin
      new_kind   = K_BR;
      new_target = bus.br_target;
    end
  end

  // The pending slot ranks below trap/irq but above mret/branch
  always_comb begin
    if (new_kind == K_TRAP || new_kind == K_IRQ || !pend_valid_q) begin
      sel_kind   = new_kind;
      sel_target = new_target;
      sel_epc    = new_epc;
    end else begin
      sel_kind   = pend_kind_q;
      sel_target = pend_target_q;
      sel_epc    = pend_epc_q;
    end
  end

  // Next-state and redirect decode
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_kind_d   = pend_kind_q;
    pend_target_d = pend_target_q;
    pend_epc_d    = pend_epc_q;
    dbg_pend_d    = dbg_pend_q;
    in_trap_d     = in_trap_q;
    mepc_d        = mepc_q;
    halt_c        = 1'b0;
    jreq_c        = 1'b0;
    jval_c        = '0;
    unique case (state_q)
      S_RUN: begin
        if (bus.mem_busy) begin
          halt_c = 1'b1;
          if (new_kind != K_NONE && (!pend_valid_q || new_kind > pend_kind_q)) begin
            pend_valid_d  = 1'b1;
            pend_kind_d   = new_kind;
            pend_target_d = new_target;
            pend_epc_d    = new_epc;
          end
          if (bus.dbg_halt_req) dbg_pend_d = 1'b1;
        end else if (sel_kind != K_NONE) begin
          jreq_c       = 1'b1;
          jval_c       = {sel_target[XLEN-1:2], 2'b00};
          pend_valid_d = 1'b0;
          state_d      = S_FLUSH;
          flush_cnt_d  = 3'(FLUSH_CYCLES);
          if (sel_kind == K_TRAP || sel_kind == K_IRQ) begin
            mepc_d    = sel_epc;
            in_trap_d = 1'b1;
          end else if (sel_kind == K_MRET) begin
            in_trap_d = 1'b0;
          end
          if (bus.dbg_halt_req) dbg_pend_d = 1'b1;
        end else if (bus.dbg_halt_req || dbg_pend_q) begin
          state_d = S_HALTED;
        end
      end
      S_FLUSH: begin
        if (bus.dbg_halt_req) dbg_pend_d = 1'b1;
        if (bus.mem_busy) begin
          halt_c = 1'b1;
        end else if (flush_cnt_q == 3'd1) begin
          flush_cnt_d = 3'd0;
          state_d     = (dbg_pend_q || bus.dbg_halt_req) ? S_HALTED : S_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      S_HALTED: begin
        halt_c = 1'b1;
        if (bus.dbg_resume_req) begin
          state_d    = S_RUN;
          dbg_pend_d = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge xreset_n) begin
    if (!xreset_n) begin
      state_q       <= S_RUN;
      flush_cnt_q   <= 3'd0;
      pend_valid_q  <= 1'b0;
      pend_kind_q   <= K_NONE;
      pend_target_q <= '0;
      pend_epc_q    <= '0;
      dbg_pend_q    <= 1'b0;
      in_trap_q     <= 1'b0;
      mepc_q        <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_kind_q   <= pend_kind_d;
      pend_target_q <= pend_target_d;
      pend_epc_q    <= pend_epc_d;
      dbg_pend_q    <= dbg_pend_d;
      in_trap_q     <= in_trap_d;
      mepc_q        <= mepc_d;
    end
  end

  // Combinational outputs are held at zero while reset is asserted
  assign bus.halt    = halt_c & xreset_n;
  assign bus.jreq    = jreq_c & xreset_n;
  assign bus.jval    = jval_c & {XLEN{xreset_n}};
  assign bus.flush   = (state_q == S_FLUSH) & xreset_n;
  assign bus.halted  = (state_q == S_HALTED) & xreset_n;
  assign bus.mepc    = mepc_q;
  assign bus.in_trap = in_trap_q;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus a randomized run
// checked against a candidate-list reference model.
module tb_pc_redirect_ctrl;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic xreset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  pc_redirect_ctrl_if #(.XLEN(32)) bus ();

  pc_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
    .clk      (clk),
    .xreset_n (xreset_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic idle();
    bus.next_pc = 32'h0; bus.mem_busy = 1'b0; bus.br_req = 1'b0; bus.br_target = 32'h0;
    bus.trap_req = 1'b0; bus.trap_pc = 32'h0; bus.mret_req = 1'b0; bus.irq = 1'b0;
    bus.irq_en = 1'b0; bus.mtvec = 32'h80; bus.dbg_halt_req = 1'b0; bus.dbg_resume_req = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    xreset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    xreset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    xreset_n = 1'b0;
    bus.mem_busy = 1'b1;
    smp();
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", bus.halt); end
    total++; if (bus.jreq !== 1'b0 || bus.jval !== 32'h0) begin bad++; $display("FAIL reset_jreq got=%b/%h exp=0/0", bus.jreq, bus.jval); end
    total++; if (bus.flush !== 1'b0 || bus.halted !== 1'b0) begin bad++; $display("FAIL reset_flush_halted got=%b/%b exp=0/0", bus.flush, bus.halted); end
    total++; if (bus.mepc !== 32'h0 || bus.in_trap !== 1'b0) begin bad++; $display("FAIL reset_mepc_intrap got=%h/%b exp=0/0", bus.mepc, bus.in_trap); end
    @(posedge clk);
    @(posedge clk);
    #1;
    idle();
    xreset_n = 1'b1;
  endtask

  task automatic test_branch();
    idle();
    bus.br_req = 1'b1; bus.br_target = 32'h100;
    smp();
    total++; if (bus.jreq !== 1'b1 || bus.jval !== 32'h100) begin bad++; $display("FAIL br_issue got=%b/%h exp=1/00000100", bus.jreq, bus.jval); end
    total++; if (bus.flush !== 1'b0 || bus.halt !== 1'b0) begin bad++; $display("FAIL br_issue_flush got=%b/%b exp=0/0", bus.flush, bus.halt); end
    nxt(); bus.br_req = 1'b0;
    smp();
    total++; if (bus.flush !== 1'b1 || bus.jreq !== 1'b0) begin bad++; $display("FAIL br_flush1 got=%b/%b exp=1/0", bus.flush, bus.jreq); end
    nxt(); smp();
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL br_flush2 got=%b exp=1", bus.flush); end
    nxt(); smp();
    total++; if (bus.flush !== 1'b0 || bus.halt !== 1'b0) begin bad++; $display("FAIL br_run got=%b/%b exp=0/0", bus.flush, bus.halt); end
    nxt();
  endtask

  task automatic test_stall();
    idle();
    bus.mem_busy = 1'b1; bus.br_req = 1'b1; bus.br_target = 32'h41;
    for (int i = 0; i < 3; i++) begin
      smp();
      total++; if (bus.halt !== 1'b1 || bus.jreq !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=%b/%b exp=1/0", i, bus.halt, bus.jreq); end
      nxt(); bus.br_req = 1'b0;
    end
    bus.mem_busy = 1'b0;
    smp();
    total++; if (bus.jreq !== 1'b1 || bus.jval !== 32'h40 || bus.halt !== 1'b0) begin bad++; $display("FAIL stall_issue got=%b/%h/%b exp=1/00000040/0", bus.jreq, bus.jval, bus.halt); end
    nxt(); bus.mem_busy = 1'b1;
    smp();
    total++; if (bus.flush !== 1'b1 || bus.halt !== 1'b1) begin bad++; $display("FAIL stall_flush_busy got=%b/%b exp=1/1", bus.flush, bus.halt); end
    nxt(); bus.mem_busy = 1'b0;
    smp();
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL stall_flush_a got=%b exp=1", bus.flush); end
    nxt(); smp();
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL stall_flush_b got=%b exp=1", bus.flush); end
    nxt(); smp();
    total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL stall_flush_end got=%b exp=0", bus.flush); end
    nxt();
  endtask

  task automatic test_priority();
    idle();
    bus.trap_req = 1'b1; bus.trap_pc = 32'h20; bus.mtvec = 32'h80;
    bus.br_req = 1'b1; bus.br_target = 32'h300;
    smp();
    total++; if (bus.jreq !== 1'b1 || bus.jval !== 32'h80) begin bad++; $display("FAIL prio_jval got=%b/%h exp=1/00000080", bus.jreq, bus.jval); end
    nxt(); bus.trap_req = 1'b0; bus.br_req = 1'b0;
    smp();
    total++; if (bus.mepc !== 32'h20 || bus.in_trap !== 1'b1) begin bad++; $display("FAIL prio_mepc got=%h/%b exp=00000020/1", bus.mepc, bus.in_trap); end
    nxt(); nxt();
    smp();
    total++; if (bus.jreq !== 1'b0 || bus.flush !== 1'b0) begin bad++; $display("FAIL prio_br_dropped got=%b/%b exp=0/0", bus.jreq, bus.flush); end
    nxt(); bus.mret_req = 1'b1;
    smp();
    total++; if (bus.jreq !== 1'b1 || bus.jval !== 32'h20) begin bad++; $display("FAIL prio_mret got=%b/%h exp=1/00000020", bus.jreq, bus.jval); end
    nxt(); bus.mret_req = 1'b0;
    smp();
    total++; if (bus.in_trap !== 1'b0) begin bad++; $display("FAIL prio_mret_intrap got=%b exp=0", bus.in_trap); end
    nxt(); nxt();
  endtask

  task automatic test_irq_mret();
    idle();
    bus.irq = 1'b1; bus.irq_en = 1'b1; bus.next_pc = 32'h1C; bus.mtvec = 32'h84;
    smp();
    total++; if (bus.jreq !== 1'b1 || bus.jval !== 32'h84) begin bad++; $display("FAIL irq_jval got=%b/%h exp=1/00000084", bus.jreq, bus.jval); end
    nxt(); bus.next_pc = 32'h84;
    smp();
    total++; if (bus.mepc !== 32'h1C || bus.in_trap !== 1'b1) begin bad++; $display("FAIL irq_mepc got=%h/%b exp=0000001c/1", bus.mepc, bus.in_trap); end
    nxt(); nxt();
    smp();
    total++; if (bus.jreq !== 1'b0) begin bad++; $display("FAIL irq_nested got=%b exp=0", bus.jreq); end
    nxt(); bus.irq = 1'b0; bus.mret_req = 1'b1;
    smp();
    total++; if (bus.jreq !== 1'b1 || bus.jval !== 32'h1C) begin bad++; $display("FAIL irq_mret got=%b/%h exp=1/0000001c", bus.jreq, bus.jval); end
    nxt(); bus.mret_req = 1'b0;
    smp();
    total++; if (bus.in_trap !== 1'b0) begin bad++; $display("FAIL irq_mret_intrap got=%b exp=0", bus.in_trap); end
    nxt(); nxt();
  endtask

  task automatic test_debug();
    idle();
    bus.br_req = 1'b1; bus.br_target = 32'h200;
    smp(); nxt();
    bus.br_req = 1'b0; bus.dbg_halt_req = 1'b1;
    smp();
    total++; if (bus.flush !== 1'b1 || bus.halted !== 1'b0) begin bad++; $display("FAIL dbg_in_flush got=%b/%b exp=1/0", bus.flush, bus.halted); end
    nxt(); bus.dbg_halt_req = 1'b0;
    smp(); nxt();
    bus.br_req = 1'b1; bus.br_target = 32'h500;
    smp();
    total++; if (bus.halted !== 1'b1 || bus.halt !== 1'b1 || bus.flush !== 1'b0) begin bad++; $display("FAIL dbg_halted got=%b/%b/%b exp=1/1/0", bus.halted, bus.halt, bus.flush); end
    total++; if (bus.jreq !== 1'b0) begin bad++; $display("FAIL dbg_ignore_br got=%b exp=0", bus.jreq); end
    nxt(); bus.br_req = 1'b0; bus.dbg_resume_req = 1'b1;
    smp();
    total++; if (bus.halted !== 1'b1 || bus.jreq !== 1'b0) begin bad++; $display("FAIL dbg_resume_cycle got=%b/%b exp=1/0", bus.halted, bus.jreq); end
    nxt(); bus.dbg_resume_req = 1'b0;
    smp();
    total++; if (bus.halted !== 1'b0 || bus.halt !== 1'b0 || bus.jreq !== 1'b0) begin bad++; $display("FAIL dbg_run got=%b/%b/%b exp=0/0/0", bus.halted, bus.halt, bus.jreq); end
    nxt();
  endtask

  task automatic test_async_reset();
    idle();
    bus.trap_req = 1'b1; bus.trap_pc = 32'h44;
    smp(); nxt();
    bus.trap_req = 1'b0; bus.dbg_halt_req = 1'b1; bus.mem_busy = 1'b1;
    smp();
    total++; if (bus.flush !== 1'b1 || bus.halt !== 1'b1 || bus.in_trap !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b/%b/%b exp=1/1/1", bus.flush, bus.halt, bus.in_trap); end
    #2 xreset_n = 1'b0;
    #1;
    total++; if (bus.halt !== 1'b0 || bus.flush !== 1'b0 || bus.jreq !== 1'b0 || bus.halted !== 1'b0 || bus.jval !== 32'h0) begin bad++; $display("FAIL arst_outputs got=%b/%b/%b/%b/%h exp=0/0/0/0/0", bus.halt, bus.flush, bus.jreq, bus.halted, bus.jval); end
    total++; if (bus.in_trap !== 1'b0 || bus.mepc !== 32'h0) begin bad++; $display("FAIL arst_regs got=%b/%h exp=0/0", bus.in_trap, bus.mepc); end
    @(posedge clk);
    @(posedge clk);
    #1;
    idle();
    xreset_n = 1'b1;
    smp();
    total++; if (bus.flush !== 1'b0 || bus.halted !== 1'b0) begin bad++; $display("FAIL arst_run got=%b/%b exp=0/0", bus.flush, bus.halted); end
    nxt(); smp();
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL arst_dbg_cleared got=%b exp=0", bus.halted); end
    nxt();
  endtask

  // Reference model: each cycle the live requests and the pending slot form a
  // ranked candidate list; the best one is issued, or parked when stalled.
  task automatic test_random();
    int m_mode, m_left, m_pk;
    bit m_pv, m_dbg, m_intrap;
    logic [31:0] m_pt, m_pe, m_mepc;
    int rk[5], kd[5];
    bit ok[5];
    logic [31:0] tg[5], ep[5];
    int bi, li;
    logic e_halt, e_jreq, e_flush, e_halted;
    logic [31:0] e_jval;

    do_reset();
    m_mode = 0; m_left = 0; m_pk = 0; m_pv = 0; m_dbg = 0; m_intrap = 0;
    m_pt = 0; m_pe = 0; m_mepc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.next_pc        = $urandom;
      bus.mem_busy       = ($urandom_range(0, 3) == 0);
      bus.br_req         = ($urandom_range(0, 3) == 0);
      bus.br_target      = $urandom;
      bus.trap_req       = ($urandom_range(0, 15) == 0);
      bus.trap_pc        = $urandom;
      bus.mret_req       = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) bus.irq = ~bus.irq;
      bus.irq_en         = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.mtvec = $urandom;
      bus.dbg_halt_req   = ($urandom_range(0, 39) == 0);
      bus.dbg_resume_req = ($urandom_range(0, 3) == 0);
      smp();

      total++; if (bus.mepc !== m_mepc || bus.in_trap !== m_intrap) begin bad++; if (bad < 20) $display("FAIL rnd_regs cyc=%0d got=%h/%b exp=%h/%b", cyc, bus.mepc, bus.in_trap, m_mepc, m_intrap); end

      ok[0] = bus.trap_req;                            rk[0] = 40; kd[0] = 4;    tg[0] = bus.mtvec;     ep[0] = bus.trap_pc;
      ok[1] = bus.irq && bus.irq_en && !m_intrap;      rk[1] = 30; kd[1] = 3;    tg[1] = bus.mtvec;     ep[1] = bus.next_pc;
      ok[2] = m_pv;                                    rk[2] = 25; kd[2] = m_pk; tg[2] = m_pt;          ep[2] = m_pe;
      ok[3] = bus.mret_req;                            rk[3] = 20; kd[3] = 2;    tg[3] = m_mepc;        ep[3] = 32'h0;
      ok[4] = bus.br_req;                              rk[4] = 10; kd[4] = 1;    tg[4] = bus.br_target; ep[4] = 32'h0;
      bi = -1; li = -1;
      for (int i = 0; i < 5; i++) begin
        if (ok[i] && (bi < 0 || rk[i] > rk[bi])) bi = i;
        if (i != 2 && ok[i] && (li < 0 || rk[i] > rk[li])) li = i;
      end

      e_halt = 0; e_jreq = 0; e_jval = 32'h0; e_flush = 0; e_halted = 0;
      if (m_mode == 0) begin
        if (bus.mem_busy) begin
          e_halt = 1;
          if (li >= 0 && (!m_pv || kd[li] > m_pk)) begin
            m_pv = 1; m_pk = kd[li]; m_pt = tg[li]; m_pe = ep[li];
          end
          if (bus.dbg_halt_req) m_dbg = 1;
        end else if (bi >= 0) begin
          e_jreq = 1;
          e_jval = tg[bi] & 32'hFFFF_FFFC;
          m_pv = 0;
          if (kd[bi] >= 3) begin m_mepc = ep[bi]; m_intrap = 1; end
          else if (kd[bi] == 2) m_intrap = 0;
          m_mode = 1; m_left = FC;
          if (bus.dbg_halt_req) m_dbg = 1;
        end else if (bus.dbg_halt_req || m_dbg) begin
          m_mode = 2;
        end
      end else if (m_mode == 1) begin
        e_flush = 1;
        if (bus.dbg_halt_req) m_dbg = 1;
        if (bus.mem_busy) e_halt = 1;
        else begin
          m_left--;
          if (m_left == 0) m_mode = m_dbg ? 2 : 0;
        end
      end else begin
        e_halt = 1; e_halted = 1;
        if (bus.dbg_resume_req) begin m_mode = 0; m_dbg = 0; end
      end

      total++; if (bus.halt !== e_halt || bus.flush !== e_flush || bus.halted !== e_halted) begin bad++; if (bad < 20) $display("FAIL rnd_status cyc=%0d got=%b%b%b exp=%b%b%b", cyc, bus.halt, bus.flush, bus.halted, e_halt, e_flush, e_halted); end
      total++; if (bus.jreq !== e_jreq || bus.jval !== e_jval) begin bad++; if (bad < 20) $display("FAIL rnd_redirect cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.jreq, bus.jval, e_jreq, e_jval); end
      nxt();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_branch();
    test_stall();
    test_priority();
    test_irq_mret();
    test_debug();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
